// File: rtl/pll_reset_sequencer.sv
// Sequences the ECP5 EHXPLLL reset pulse, lock qualification and staggered per-domain reset release.
// Build option: define PLL_RETRY_EN to retry forever on lock timeout instead of latching in FAULT.
module pll_reset_sequencer #(
  parameter int unsigned PLL_RST_CYCLES = 16,
  parameter int unsigned LOCK_TIMEOUT   = 65536,
  parameter int unsigned SETTLE_CYCLES  = 1024,
  parameter int unsigned STAGGER        = 4,
  parameter int unsigned NDOM           = 2
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            locked,
  input  logic            force_reset,
  input  logic            clear_lost,
  output logic            pll_rst,
  output logic [NDOM-1:0] dom_rst_n,
  output logic            ready,
  output logic            lock_lost,
  output logic [3:0]      retries
);

  localparam int unsigned RET_W   = 4;
  localparam int unsigned REL_MAX = NDOM * STAGGER;
  localparam int unsigned MAX_A   = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES : LOCK_TIMEOUT;
  localparam int unsigned MAX_B   = (SETTLE_CYCLES > REL_MAX) ? SETTLE_CYCLES : REL_MAX;
  localparam int unsigned CNT_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX) + 1;
  localparam int unsigned DOM_IW  = (NDOM > 1) ? $clog2(NDOM) : 1;

`ifdef PLL_RETRY_EN
  typedef enum logic [2:0] {
    ST_PLLRST, ST_WAITLOCK, ST_SETTLE, ST_RELEASE, ST_RUN
  } state_e;
`else
  typedef enum logic [2:0] {
    ST_PLLRST, ST_WAITLOCK, ST_SETTLE, ST_RELEASE, ST_RUN, ST_FAULT
  } state_e;
`endif

  state_e             r_state;
  state_e             w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic [1:0]         r_sync;
  logic               w_locked_s;
  logic               r_pll_rst;
  logic               w_pll_rst_nxt;
  logic [NDOM-1:0]    r_dom_rst_n;
  logic [NDOM-1:0]    w_dom_nxt;
  logic               r_ready;
  logic               w_ready_nxt;
  logic               r_lock_lost;
  logic               w_lost_nxt;
  logic [RET_W-1:0]   r_retries;
  logic [RET_W-1:0]   w_retries_nxt;

  assign w_locked_s = r_sync[1];

  // State, counter, synchroniser and all outputs are registered here
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_PLLRST;
      r_cnt       <= '0;
      r_sync      <= '0;
      r_pll_rst   <= 1'b1;
      r_dom_rst_n <= '0;
      r_ready     <= 1'b0;
      r_lock_lost <= 1'b0;
      r_retries   <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_sync      <= {r_sync[0], locked};
      r_pll_rst   <= w_pll_rst_nxt;
      r_dom_rst_n <= w_dom_nxt;
      r_ready     <= w_ready_nxt;
      r_lock_lost <= w_lost_nxt;
      r_retries   <= w_retries_nxt;
    end
  end

  // Next state and next output values
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt + CNT_W'(1);
    w_pll_rst_nxt = 1'b0;
    w_dom_nxt     = r_dom_rst_n;
    w_ready_nxt   = 1'b0;
    w_lost_nxt    = r_lock_lost & ~clear_lost;
    w_retries_nxt = r_retries;

    case (r_state)
      ST_PLLRST: begin
        w_pll_rst_nxt = 1'b1;
        w_dom_nxt     = '0;
        if (r_cnt == CNT_W'(PLL_RST_CYCLES - 1)) begin
          w_state_nxt   = ST_WAITLOCK;
          w_cnt_nxt     = '0;
          w_pll_rst_nxt = 1'b0;
        end
      end

      ST_WAITLOCK: begin
        w_dom_nxt = '0;
        if (w_locked_s) begin
          w_state_nxt = ST_SETTLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt == CNT_W'(LOCK_TIMEOUT - 1)) begin
          w_cnt_nxt = '0;
          if (r_retries != '1) w_retries_nxt = r_retries + RET_W'(1);
`ifdef PLL_RETRY_EN
          w_state_nxt   = ST_PLLRST;
          w_pll_rst_nxt = 1'b1;
`else
          w_state_nxt   = ST_FAULT;
`endif
        end
      end

      // Any unlocked cycle restarts qualification without counting as a retry
      ST_SETTLE: begin
        w_dom_nxt = '0;
        if (!w_locked_s) begin
          w_state_nxt = ST_WAITLOCK;
          w_cnt_nxt   = '0;
        end else if (r_cnt == CNT_W'(SETTLE_CYCLES - 1)) begin
          w_cnt_nxt    = '0;
          w_dom_nxt[0] = 1'b1;
          if (NDOM == 1) begin
            w_state_nxt = ST_RUN;
            w_ready_nxt = 1'b1;
          end else begin
            w_state_nxt = ST_RELEASE;
          end
        end
      end

      ST_RELEASE: begin
        if (!w_locked_s) begin
          w_state_nxt   = ST_PLLRST;
          w_cnt_nxt     = '0;
          w_pll_rst_nxt = 1'b1;
          w_dom_nxt     = '0;
        end else begin
          for (int unsigned k = 1; k < NDOM; k++) begin
            if (r_cnt == CNT_W'(k * STAGGER - 1)) w_dom_nxt[DOM_IW'(k)] = 1'b1;
          end
          if (r_cnt == CNT_W'((NDOM - 1) * STAGGER - 1)) begin
            w_state_nxt = ST_RUN;
            w_cnt_nxt   = '0;
            w_ready_nxt = 1'b1;
          end
        end
      end

      ST_RUN: begin
        w_cnt_nxt   = '0;
        w_dom_nxt   = '1;
        w_ready_nxt = 1'b1;
        if (!w_locked_s) begin
          w_state_nxt   = ST_PLLRST;
          w_pll_rst_nxt = 1'b1;
          w_dom_nxt     = '0;
          w_ready_nxt   = 1'b0;
          w_lost_nxt    = 1'b1;
        end
      end

`ifndef PLL_RETRY_EN
      ST_FAULT: begin
        w_cnt_nxt = '0;
        w_dom_nxt = '0;
      end
`endif

      default: begin
        w_state_nxt   = ST_PLLRST;
        w_cnt_nxt     = '0;
        w_pll_rst_nxt = 1'b1;
        w_dom_nxt     = '0;
      end
    endcase

    // Restart request overrides everything except the sticky lock_lost and retries
    if (force_reset) begin
      w_state_nxt   = ST_PLLRST;
      w_cnt_nxt     = '0;
      w_pll_rst_nxt = 1'b1;
      w_dom_nxt     = '0;
      w_ready_nxt   = 1'b0;
      w_retries_nxt = r_retries;
    end
  end

  assign pll_rst   = r_pll_rst;
  assign dom_rst_n = r_dom_rst_n;
  assign ready     = r_ready;
  assign lock_lost = r_lock_lost;
  assign retries   = r_retries;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Scoreboard bench: stimulus queues the expected output transitions (cycle, value); a monitor checks every change.
module tb_pll_reset_sequencer;

  typedef struct {
    int         cyc;
    logic [8:0] vec;
    int         id;
  } exp_t;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       locked;
  logic       force_reset;
  logic       clear_lost;
  logic       pll_rst;
  logic [1:0] dom_rst_n;
  logic       ready;
  logic       lock_lost;
  logic [3:0] retries;

  exp_t       exp_q[$];
  int         cyc    = 0;
  int         n_chk  = 0;
  int         n_fail = 0;
  int         n_push = 0;
  logic [8:0] prev   = 'x;

  pll_reset_sequencer #(
    .PLL_RST_CYCLES(4),
    .LOCK_TIMEOUT  (32),
    .SETTLE_CYCLES (8),
    .STAGGER       (2),
    .NDOM          (2)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .locked     (locked),
    .force_reset(force_reset),
    .clear_lost (clear_lost),
    .pll_rst    (pll_rst),
    .dom_rst_n  (dom_rst_n),
    .ready      (ready),
    .lock_lost  (lock_lost),
    .retries    (retries)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [8:0] mk(input logic p, input logic [1:0] d, input logic r,
                                    input logic l, input logic [3:0] n);
    return {p, d, r, l, n};
  endfunction

  task automatic push(input int c, input logic [8:0] v);
    exp_t e;
    e.cyc = c;
    e.vec = v;
    e.id  = n_push;
    exp_q.push_back(e);
    n_push++;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Monitor: every observed output change must match the head of the queue, value and cycle
  always @(negedge clock) begin
    logic [8:0] v;
    exp_t       e;
    v = {pll_rst, dom_rst_n, ready, lock_lost, retries};
    if (v !== prev) begin
      n_chk++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_change cyc=%0d got=%b (pll,dom,rdy,lost,ret)", cyc, v);
      end else begin
        e = exp_q.pop_front();
        if (e.vec !== v || e.cyc != cyc) begin
          n_fail++;
          $display("FAIL transition_%0d got=%b at cyc %0d, want=%b at cyc %0d",
                   e.id, v, cyc, e.vec, e.cyc);
        end
      end
      prev = v;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int b, l, d, l2, f, c, h, b2, k, last;
    reset_n     = 1'b1;
    locked      = 1'b0;
    force_reset = 1'b0;
    clear_lost  = 1'b0;
    #2 reset_n  = 1'b0;
    push(1, mk(1, 2'b00, 0, 0, 4'd0));

    // Normal bring-up
    repeat (3) @(posedge clock);
    #1 reset_n = 1'b1;
    b = cyc;
    push(b + 4, mk(0, 2'b00, 0, 0, 4'd0));
    wait_until(b + 10);
    locked = 1'b1;
    l = cyc;
    push(l + 11, mk(0, 2'b01, 0, 0, 4'd0));
    push(l + 13, mk(0, 2'b11, 1, 0, 4'd0));

    // Lock loss in RUN, then relock
    wait_until(l + 20);
    locked = 1'b0;
    d = cyc;
    push(d + 3, mk(1, 2'b00, 0, 1, 4'd0));
    push(d + 7, mk(0, 2'b00, 0, 1, 4'd0));
    wait_until(d + 10);
    locked = 1'b1;
    l2 = cyc;
    push(l2 + 11, mk(0, 2'b01, 0, 1, 4'd0));
    push(l2 + 13, mk(0, 2'b11, 1, 1, 4'd0));

    // force_reset in RUN with a one-cycle lock glitch during SETTLE
    wait_until(l2 + 20);
    force_reset = 1'b1;
    f = cyc;
    push(f + 1, mk(1, 2'b00, 0, 1, 4'd0));
    push(f + 5, mk(0, 2'b00, 0, 1, 4'd0));
    push(f + 20, mk(0, 2'b01, 0, 1, 4'd0));
    push(f + 22, mk(0, 2'b11, 1, 1, 4'd0));
    wait_cyc(1);
    force_reset = 1'b0;
    wait_until(f + 8);
    locked = 1'b0;
    wait_cyc(1);
    locked = 1'b1;

    // clear_lost in RUN
    wait_until(f + 30);
    clear_lost = 1'b1;
    c = cyc;
    push(c + 1, mk(0, 2'b11, 1, 0, 4'd0));
    wait_cyc(1);
    clear_lost = 1'b0;

    // Asynchronous reset mid-RELEASE with dom_rst_n=01
    wait_until(c + 5);
    force_reset = 1'b1;
    h = cyc;
    push(h + 1, mk(1, 2'b00, 0, 0, 4'd0));
    push(h + 5, mk(0, 2'b00, 0, 0, 4'd0));
    push(h + 14, mk(0, 2'b01, 0, 0, 4'd0));
    wait_cyc(1);
    force_reset = 1'b0;
    wait_until(h + 15);
    reset_n = 1'b0;
    locked  = 1'b0;
    push(h + 15, mk(1, 2'b00, 0, 0, 4'd0));
    wait_cyc(2);

    // Lock timeout
    reset_n = 1'b1;
    b2 = cyc;
    push(b2 + 4, mk(0, 2'b00, 0, 0, 4'd0));
`ifdef PLL_RETRY_EN
    for (int i = 1; i <= 17; i++) begin
      push(b2 + 36 * i,     mk(1, 2'b00, 0, 0, 4'((i > 15) ? 15 : i)));
      push(b2 + 36 * i + 4, mk(0, 2'b00, 0, 0, 4'((i > 15) ? 15 : i)));
    end
    wait_until(b2 + 36 * 17 + 6);
    locked = 1'b1;
    k = cyc;
    push(k + 11, mk(0, 2'b01, 0, 0, 4'd15));
    push(k + 13, mk(0, 2'b11, 1, 0, 4'd15));
    last = k + 13;
`else
    push(b2 + 36, mk(0, 2'b00, 0, 0, 4'd1));
    wait_until(b2 + 38);
    locked = 1'b1;
    wait_until(b2 + 40);
    force_reset = 1'b1;
    k = cyc;
    push(k + 1, mk(1, 2'b00, 0, 0, 4'd1));
    push(k + 5, mk(0, 2'b00, 0, 0, 4'd1));
    push(k + 14, mk(0, 2'b01, 0, 0, 4'd1));
    push(k + 16, mk(0, 2'b11, 1, 0, 4'd1));
    wait_cyc(1);
    force_reset = 1'b0;
    last = k + 16;
`endif

    wait_until(last + 6);
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL pending_transitions left=%0d want=0 (next id %0d)", exp_q.size(), exp_q[0].id);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
